// File: rtl/fm_demod_sched_if.sv
// Datapath handshake between the FM demod scheduler and the demodulator.
// master = scheduler side, slave = demodulator datapath side.
interface fm_demod_sched_if;
  logic [7:0] i_o;
  logic [7:0] q_o;
  logic       dp_valid_o;
  logic       dp_ready_i;
  logic [7:0] dp_data_i;
  logic       dp_valid_i;

  modport master (
    output i_o, q_o, dp_valid_o,
    input  dp_ready_i, dp_data_i, dp_valid_i
  );

  modport slave (
    input  i_o, q_o, dp_valid_o,
    output dp_ready_i, dp_data_i, dp_valid_i
  );
endinterface

// File: rtl/fm_demod_sched.sv
// FM demodulator scheduler: pairs an interleaved I/Q byte stream, buffers
// pairs in a small FIFO ahead of the demod datapath, tracks results in
// flight and decimates the returned demodulated samples.
module fm_demod_sched #(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [7:0]              data_i,
  input  logic                    valid_i,
  fm_demod_sched_if.master        dp,
  output logic [7:0]              data_o,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic                    overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEC_LAST = 4'(DECIM - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_next;
  logic        phase;            // 0: expecting I, 1: expecting Q
  logic [7:0]  pend_i;
  logic [7:0]  mem_i [FIFO_DEPTH];
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push_req, push_ok;
  logic        enter_run, leave_run;
  logic [4:0]  inflight;
  logic [3:0]  dec_cnt;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = !empty && dp.dp_ready_i;
  assign push_req  = (state == RUN) && valid_i && phase;
  // A same-cycle pop frees the slot, so a push onto a full FIFO is still taken.
  assign push_ok   = push_req && (!full || pop);
  assign enter_run = (state == IDLE) && start_i;
  assign leave_run = (state == RUN) && !start_i;

  assign dp.dp_valid_o = !empty;
  assign dp.i_o        = empty ? '0 : mem_i[rd_ptr[AW-1:0]];
  assign dp.q_o        = empty ? '0 : mem_q[rd_ptr[AW-1:0]];
  assign busy_o        = (state != IDLE);

  // Session state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Session next-state: restart from DRAIN takes priority over going idle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_i) state_next = RUN;
      RUN:     if (!start_i) state_next = DRAIN;
      DRAIN: begin
        if (start_i)                         state_next = RUN;
        else if (empty && inflight == 5'd0)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte pairing: hold I until its Q arrives; an unpaired I dies at session edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= 1'b0;
      pend_i <= '0;
    end else if (enter_run || leave_run) begin
      phase  <= 1'b0;
    end else if ((state == RUN) && valid_i) begin
      if (!phase) pend_i <= data_i;
      phase <= ~phase;
    end
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_i[wr_ptr[AW-1:0]] <= pend_i;
      mem_q[wr_ptr[AW-1:0]] <= data_i;
    end
  end

  // Sticky overflow flag, cleared only when a new session starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      overflow_o <= 1'b0;
    else if (enter_run)           overflow_o <= 1'b0;
    else if (push_req && !push_ok) overflow_o <= 1'b1;
  end

  // Results-in-flight counter, saturating at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (pop && !dp.dp_valid_i) begin
      if (inflight != 5'd31) inflight <= inflight + 5'd1;
    end else if (dp.dp_valid_i && !pop) begin
      if (inflight != 5'd0) inflight <= inflight - 5'd1;
    end
  end

  // Decimator: forward every DECIM-th result, registered, with a one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (dp.dp_valid_i && dec_cnt == DEC_LAST) begin
        data_o  <= dp.dp_data_i;
        valid_o <= 1'b1;
      end
      if (enter_run)                 dec_cnt <= '0;
      else if (dp.dp_valid_i)        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 4'd1;
    end
  end

endmodule

// File: doc/fm_demod_sched.md
FM_DEMOD_SCHED -- requirements
Module: fm_demod_sched

Interface
REQ-001 Parameter DECIM, default 4, meaning: forward one of every DECIM demodulator results (legal 1..16).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning: number of I/Q pair entries buffered ahead of the demodulator (power of two, 2..16).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  level; high = stream session active, falling = end of stream.
REQ-006 data_i  input  8  signed sample byte, interleaved I, Q, I, Q, ...
REQ-007 valid_i  input  1  data_i carries a byte this cycle.
REQ-008 i_o  output  8  signed I of the FIFO head pair, to datapath.
REQ-009 q_o  output  8  signed Q of the FIFO head pair, to datapath.
REQ-010 dp_valid_o  output  1  head pair is presented to the datapath.
REQ-011 dp_ready_i  input  1  datapath accepts the presented pair.
REQ-012 dp_data_i  input  8  demodulated result from the datapath.
REQ-013 dp_valid_i  input  1  dp_data_i valid this cycle.
REQ-014 data_o  output  8  decimated demodulated output, registered.
REQ-015 valid_o  output  1  one-cycle pulse qualifying data_o.
REQ-016 busy_o  output  1  high in RUN or DRAIN.
REQ-017 overflow_o  output  1  sticky: a complete pair was dropped on a full FIFO.

Function
REQ-018 FSM states IDLE, RUN, DRAIN; IDLE->RUN when start_i=1; RUN->DRAIN when start_i=0; DRAIN->IDLE when FIFO empty and in-flight count 0; DRAIN->RUN if start_i returns to 1.
REQ-019 On IDLE->RUN: byte phase set to I, decimation counter cleared, overflow_o cleared.
REQ-020 In RUN only, each valid_i byte is captured: phase I stores it as pending I; phase Q pairs it with pending I and pushes {I,Q} to the FIFO; phase toggles per accepted byte.
REQ-021 valid_i ignored in IDLE and DRAIN; an unpaired pending I at RUN->DRAIN is discarded and phase resets to I.
REQ-022 Push with FIFO full: pair dropped, FIFO unchanged, overflow_o set to 1 next cycle.
REQ-023 Push and pop in the same cycle with FIFO full: pop first, push accepted, no overflow.
REQ-024 dp_valid_o = FIFO not empty (combinational from FIFO state); i_o/q_o = head entry; i_o/q_o = 0 when empty.
REQ-025 Transfer = dp_valid_o and dp_ready_i; head popped on transfer; pairs issued strictly in arrival order.
REQ-026 In-flight counter (5 bits, saturating at 31 and 0) increments on transfer, decrements on dp_valid_i, unchanged when both occur in the same cycle.
REQ-027 Decimation counter counts dp_valid_i pulses 0..DECIM-1; on the pulse where counter = DECIM-1, dp_data_i registered to data_o and valid_o pulses next cycle; counter wraps to 0.
REQ-028 DECIM=1: every dp_valid_i forwarded, latency 1 cycle.
REQ-029 data_o holds last forwarded value between pulses; valid_o never high two cycles unless two consecutive forwards.
REQ-030 dp_valid_i accepted in every state (late results after DRAIN still counted and forwarded).
REQ-031 Pointers wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.

Reset
REQ-032 rst=1 immediately forces: state IDLE, FIFO empty, pointers 0, phase I, in-flight 0, decimation counter 0.
REQ-033 rst=1 immediately forces outputs: i_o=0, q_o=0, dp_valid_o=0, data_o=0, valid_o=0, busy_o=0, overflow_o=0.
REQ-034 Reset mid-session discards all buffered pairs and pending I; no output pulse on reset release.

Verification
REQ-035 Bytes 10,-20,30,-40 with dp_ready_i=1, start_i=1 -> dp_valid_o pulses with (i_o,q_o)=(10,-20) then (30,-40), in order.
REQ-036 dp_ready_i=0, 5 pairs streamed, FIFO_DEPTH=4 -> FIFO holds first 4 pairs, 5th dropped, overflow_o=1 until next IDLE->RUN.
REQ-037 DECIM=4, dp_valid_i with values 1..8 -> valid_o pulses exactly twice, data_o=4 then 8, each one cycle after the source pulse.
REQ-038 start_i falls after 3 bytes (7,8,9), one result outstanding -> pending 9 discarded, busy_o stays 1 until dp_valid_i arrives, then IDLE, busy_o=0.
REQ-039 rst asserted with 3 pairs buffered and in-flight=2 -> all outputs 0 same cycle; after release, start_i and pair (1,2) -> first issued pair is (1,2).
REQ-040 FIFO full, same-cycle transfer and new pair push -> occupancy stays 4, overflow_o stays 0.
